lcd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the character-LCD driver between up to NREQ requesters. It accepts one 10-bit command/data word per request, issues it to the driver with a single-cycle `lcd_enable` pulse, tracks the driver's `busy` handshake through to completion, and reports completion or timeout back to the winning requester. It sits between the application clients (text writer, cursor control, status updater) and the LCD driver's `lcd_enable`/`lcd_bus`/`busy` port.

---
 rtl/lcd_arbiter.sv | 143 ++++++++++++++
 tb/tb_lcd_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_arbiter.sv
// Round-robin arbiter/sequencer sharing one character-LCD driver among NREQ clients.
// Optional ownership lock enabled by defining LCD_ARB_LOCK_EN.
module lcd_arbiter #(
    parameter int NREQ        = 4,
    parameter int ACK_TIMEOUT = 8,
    parameter int OW          = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [10*NREQ-1:0] req_bus,
    input  logic [NREQ-1:0]    req_lock,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    input  logic               lcd_busy,
    output logic               lcd_enable,
    output logic [9:0]         lcd_bus,
    output logic [OW-1:0]      owner,
    output logic               active
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t          state, state_n;
    logic [OW-1:0]   ptr, ptr_n, owner_n, win, cand;
    logic [9:0]      bus_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic [NREQ-1:0] eligible, win_oh, owner_oh, gnt_n, done_n, err_n;
    logic            enable_n, found;

    function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return OW'(s);
    endfunction

    // Candidate set and round-robin winner, scanning upward from ptr
    always_comb begin
        eligible = req;
        owner_oh = '0;
        owner_oh[owner] = 1'b1;
`ifdef LCD_ARB_LOCK_EN
        if (req_lock[owner]) eligible = req & owner_oh;
`endif
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = wrap_idx(ptr, i);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_oh = '0;
        win_oh[win] = 1'b1;
    end

`ifndef LCD_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Next state plus next values of every registered output
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        owner_n  = owner;
        bus_n    = lcd_bus;
        cnt_n    = cnt;
        enable_n = 1'b0;
        gnt_n    = '0;
        done_n   = '0;
        err_n    = '0;
        cnt_inc  = (cnt == CW'(ACK_TIMEOUT)) ? cnt : cnt + 1'b1;
        case (state)
            IDLE: begin
                if (found && !lcd_busy) begin
                    bus_n    = req_bus[int'(win)*10 +: 10];
                    owner_n  = win;
                    gnt_n    = win_oh;
                    enable_n = 1'b1;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                ptr_n   = (owner == OW'(NREQ-1)) ? '0 : owner + 1'b1;
                cnt_n   = '0;
                state_n = WAIT_HI;
            end
            WAIT_HI: begin
                if (lcd_busy) begin
                    state_n = WAIT_LO;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CW'(ACK_TIMEOUT)) begin
                        err_n   = owner_oh;
                        state_n = IDLE;
                    end
                end
            end
            WAIT_LO: begin
                if (!lcd_busy) begin
                    done_n  = owner_oh;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A reset mid-word drops it silently; IDLE then waits out the driver's busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            lcd_bus    <= '0;
            cnt        <= '0;
            lcd_enable <= 1'b0;
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            active     <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            owner      <= owner_n;
            lcd_bus    <= bus_n;
            cnt        <= cnt_n;
            lcd_enable <= enable_n;
            gnt        <= gnt_n;
            done       <= done_n;
            err        <= err_n;
            active     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_lcd_arbiter.sv
// Directed self-checking bench for lcd_arbiter; the driver busy handshake is played by the stimulus.
// Expected grant order depends on whether LCD_ARB_LOCK_EN is defined.
module tb_lcd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_lock, gnt, done, err;
    logic [39:0] req_bus;
    logic        lcd_busy, lcd_enable, active;
    logic [9:0]  lcd_bus;
    logic [1:0]  owner;

    int pass_count  = 0;
    int check_count = 0;
    int fail_count  = 0;

    logic [9:0] bus_word [4] = '{10'h091, 10'h1A2, 10'h2B3, 10'h3C4};

    lcd_arbiter #(.NREQ(4), .ACK_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_bus(req_bus), .req_lock(req_lock),
        .gnt(gnt), .done(done), .err(err), .lcd_busy(lcd_busy),
        .lcd_enable(lcd_enable), .lcd_bus(lcd_bus), .owner(owner), .active(active)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitGnt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 4'b0000 && n < 60);
        checkOutput("gnt_seen", 40'(gnt != 4'b0000), 40'd1);
    endtask

    // One complete word: grant to idx, driver busy for busy_cycles, then done
    task automatic applyStimulus(input string tag, input int idx, input int busy_cycles,
                                 input logic [3:0] raise);
        int         n;
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        waitGnt(n);
        checkOutput({tag, ".latency"}, 40'(n), 40'd1);
        checkOutput({tag, ".gnt"}, 40'(gnt), 40'(oh));
        checkOutput({tag, ".enable"}, 40'(lcd_enable), 40'd1);
        checkOutput({tag, ".bus"}, 40'(lcd_bus), 40'(bus_word[idx]));
        checkOutput({tag, ".owner"}, 40'(owner), 40'(idx));
        checkOutput({tag, ".active"}, 40'(active), 40'd1);
        req = (req & ~oh) | raise;
        tick();
        checkOutput({tag, ".pulse"}, 40'({gnt, lcd_enable}), 40'd0);
        lcd_busy = 1'b1;
        for (int i = 0; i < busy_cycles; i++) begin
            tick();
            checkOutput({tag, ".quiet"}, 40'({done, err, gnt}), 40'd0);
        end
        lcd_busy = 1'b0;
        tick();
        checkOutput({tag, ".done"}, 40'(done), 40'(oh));
        checkOutput({tag, ".err"}, 40'(err), 40'd0);
        checkOutput({tag, ".idle"}, 40'(active), 40'd0);
    endtask

    initial begin
        int   n;
        logic saw;

        // Reset with the driver still initialising
        rst      = 1'b1;
        lcd_busy = 1'b1;
        req      = 4'b0000;
        req_lock = 4'b0000;
        req_bus  = {bus_word[3], bus_word[2], bus_word[1], bus_word[0]};
        repeat (3) tick();
        checkOutput("reset.outs", 40'({gnt, done, err, lcd_enable, active}), 40'd0);
        checkOutput("reset.owner", 40'(owner), 40'd0);
        checkOutput("reset.bus", 40'(lcd_bus), 40'd0);

        // No grant while busy is held high
        rst = 1'b0;
        req = 4'b0001;
        saw = 1'b0;
        repeat (100) begin
            tick();
            if (gnt != 4'b0000) saw = 1'b1;
        end
        checkOutput("init.nognt", 40'(saw), 40'd0);
        lcd_busy = 1'b0;
        applyStimulus("init", 0, 4, 4'b0000);

        // Round robin from ptr=0 over all four clients
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        applyStimulus("rr0", 0, 20, 4'b0000);
        applyStimulus("rr1", 1, 20, 4'b0000);
        applyStimulus("rr2", 2, 20, 4'b0000);
        applyStimulus("rr3", 3, 20, 4'b0001);
        applyStimulus("rr4", 0, 20, 4'b0000);

        // Acknowledge timeout; later req_bus changes must not reach lcd_bus
        req = 4'b0100;
        waitGnt(n);
        checkOutput("to.gnt", 40'(gnt), 40'h4);
        req = 4'b0000;
        req_bus[29:20] = 10'h155;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("to.wait", 40'({err, done}), 40'd0);
        end
        tick();
        checkOutput("to.err", 40'(err), 40'h4);
        checkOutput("to.done", 40'(done), 40'd0);
        checkOutput("to.idle", 40'(active), 40'd0);
        checkOutput("to.bushold", 40'(lcd_bus), 40'(bus_word[2]));
        req_bus[29:20] = bus_word[2];
        req = 4'b0010;
        applyStimulus("after_to", 1, 3, 4'b0000);

        // Reset while waiting for busy to fall
        req = 4'b1000;
        waitGnt(n);
        checkOutput("mr.gnt", 40'(gnt), 40'h8);
        req = 4'b0000;
        tick();
        lcd_busy = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checkOutput("mr.outs", 40'({gnt, done, err, lcd_enable, active}), 40'd0);
        checkOutput("mr.owner", 40'(owner), 40'd0);
        checkOutput("mr.bus", 40'(lcd_bus), 40'd0);
        rst = 1'b0;
        req = 4'b0001;
        saw = 1'b0;
        repeat (25) begin
            tick();
            if ({gnt, done, err} != 12'd0) saw = 1'b1;
        end
        checkOutput("mr.silent", 40'(saw), 40'd0);
        lcd_busy = 1'b0;
        applyStimulus("mr.next", 0, 2, 4'b0000);

        // Ownership lock requested by client 2 while client 0 also waits
        req      = 4'b0100;
        req_lock = 4'b0100;
        applyStimulus("lock1", 2, 3, 4'b0101);
`ifdef LCD_ARB_LOCK_EN
        applyStimulus("lock2", 2, 3, 4'b0100);
        applyStimulus("lock3", 2, 3, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("lock.hold", 40'(gnt), 40'd0);
        end
        req_lock = 4'b0000;
        applyStimulus("lock4", 0, 3, 4'b0000);
`else
        applyStimulus("nolock2", 0, 3, 4'b0000);
        applyStimulus("nolock3", 2, 3, 4'b0000);
        req_lock = 4'b0000;
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
